register_file_32x32: RTL
========================

// Module: register_file_32x32
// PURPOSE
//   Architectural integer register file of the single-cycle processor. Two combinational
//   read ports feed the ALU operand path: read_data2 drives input 0 of the 32-bit ALU-source
//   2:1 mux, whose input 1 is the sign-extended immediate. One synchronous write port
//   accepts the write-back value. Register 0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the read/write data ports
//   ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH (32 entries)
//   BYPASS      1   1 = write-to-read forwarding in the same cycle; 0 = reads return stored value only
// PORTS
//   clk         in   1           rising-edge clock
//   reset       in   1           asynchronous, active-high; clears every register
//   read_reg1   in   ADDR_WIDTH  index for read port 1
//   read_reg2   in   ADDR_WIDTH  index for read port 2
//   write_reg   in   ADDR_WIDTH  index for the write port
//   write_data  in   DATA_WIDTH  value to write
//   reg_write   in   1           write enable, sampled on the rising edge of clk
//   read_data1  out  DATA_WIDTH  contents of read_reg1 (ALU operand A)
//   read_data2  out  DATA_WIDTH  contents of read_reg2 (to ALU-source mux input 0)
// BEHAVIOUR
//   Storage: 2**ADDR_WIDTH x DATA_WIDTH flops. Entry 0 is never written and always reads 0.
//   Reset: on reset rising, all entries clear to 0 immediately, without waiting for clk.
//     While reset=1, writes are ignored and read_data1/read_data2 are 0 for every address.
//     A write whose clk edge coincides with reset=1 is dropped.
//     Write behaviour resumes on the first clk edge after reset deasserts.
//   Write: at posedge clk with reset=0, reg_write=1 and write_reg!=0, write_data goes to
//     entry[write_reg]. With reg_write=0, or with write_reg=0, no entry changes.
//   Read: purely combinational with zero cycles of latency. read_dataN = 0 if read_regN=0.
//     Otherwise read_dataN = entry[read_regN]. Reads do not depend on clk.
//   Bypass (BYPASS=1): if reg_write=1, reset=0, write_reg!=0 and read_regN==write_reg, then
//     read_dataN=write_data in the same cycle, ahead of the clock edge. Both ports bypass
//     independently. Both ports may read the same address.
//   BYPASS=0: read_dataN shows the old value until the edge and the new value after it.
//   Read-during-write to another address: unaffected; returns the stored value.
//   Arithmetic: none; values are stored and returned bit-exact with no sign handling.
//   Out-of-range indices: impossible by construction, because the depth is a full power of two.
//   No X propagation after reset: every entry has a defined value.
// TESTING
//   1 Reset: write 0xDEADBEEF to r5, then pulse reset mid-cycle. read_reg1=5 must give 0
//     before the next clk edge, which checks the asynchronous clear.
//   2 Basic write/read: write r1=0x5F5F5F5F and r31=0xFFFFFFFF on consecutive edges. Then
//     read_reg1=1 and read_reg2=31 must give 0x5F5F5F5F and 0xFFFFFFFF.
//   3 Zero register: write r0=0x12345678 with reg_write=1. Both ports reading 0 must give 0,
//     including within the write cycle itself, with BYPASS=1 and with BYPASS=0.
//   4 Enable low: with r7=0xA5A5A5A5, drive write_reg=7, write_data=0x0 and reg_write=0.
//     r7 must stay 0xA5A5A5A5.
//   5 Bypass: with BYPASS=1, r3=0x11111111, write r3=0x22222222 and read_reg1=read_reg2=3.
//     Both ports must show 0x22222222 before the edge and after it. With BYPASS=0, both
//     ports show 0x11111111 before the edge and 0x22222222 after it.
//   6 ALU-source integration: read_data2 from r4=0x0000000A feeds the ALU-source mux with
//     imm=0xFFFFFFFC. With select=0 the mux output is 0x0000000A; with select=1 it is
//     0xFFFFFFFC.

Source files
------------

// File: rtl/register_file_32x32.sv
// Architectural register file: two combinational read ports, one clocked write port.
// Entry 0 always reads zero; BYPASS forwards a pending write to the read ports in the same cycle.
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_en;

    // A write is only live outside reset and never targets the zero register.
    assign wr_en = reg_write && !reset && (write_reg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-register and reset forcing take priority over forwarding.
    always_comb begin
        read_data1 = regs_q[read_reg1];
        read_data2 = regs_q[read_reg2];
        if (BYPASS && wr_en && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (BYPASS && wr_en && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end
        if (reset || (read_reg1 == '0)) begin
            read_data1 = '0;
        end
        if (reset || (read_reg2 == '0)) begin
            read_data2 = '0;
        end
    end

endmodule
